alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Upstream issue/capture stage that wraps the team's 32-bit combinational ALU. It accepts operation requests (operandA, operandB, 3-bit command) over a valid/ready handshake and holds them stable on the ALU inputs for a fixed settle window. It then registers the ALU result and flags and presents them downstream over a second valid/ready handshake. It also keeps a completed-operation count and a sticky overflow flag for the status path.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
SETTLE_CYCLES, 4, cycles operands are held on the ALU before capture; legal range 1..255.
CNT_WIDTH, 16, width of op_count.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  stage can accept a request
operandA  input  WIDTH  request operand A
operandB  input  WIDTH  request operand B
command  input  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
alu_operandA  output  WIDTH  registered operand A to the ALU
alu_operandB  output  WIDTH  registered operand B to the ALU
alu_command  output  3  registered command to the ALU
alu_result  input  WIDTH  ALU result
alu_carryout  input  1  ALU carryout
alu_zero  input  1  ALU zero
alu_overflow  input  1  ALU overflow
out_valid  output  1  captured result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  captured result
carryout  output  1  captured carryout
zero  output  1  captured zero
overflow  output  1  captured overflow
op_count  output  CNT_WIDTH  completed output handshakes, saturating
sticky_overflow  output  1  set by any captured overflow
clear_sticky  input  1  clears sticky_overflow

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high.
- Reset values (reset high at a rising edge):
  - state = IDLE.
  - All registered outputs = 0, including out_valid, op_count and sticky_overflow.
  - in_ready = 0 while reset is high.
- States: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Forced 0 when reset is high.
- Accept: in_valid & in_ready at an edge.
  - Latches operandA/operandB/command into alu_operandA/alu_operandB/alu_command.
  - Sets settle_cnt = SETTLE_CYCLES and moves to SETTLE.
- alu_* outputs change only on accept. They are stable at all other times, including in HOLD.
- SETTLE:
  - At each edge with settle_cnt > 1: decrement settle_cnt.
  - At the edge with settle_cnt == 1: capture alu_result/carryout/zero/overflow into result/carryout/zero/overflow, set out_valid = 1, go to HOLD.
  - in_valid is ignored in SETTLE.
- Latency: a request accepted at edge N produces out_valid = 1 after edge N+SETTLE_CYCLES.
- HOLD:
  - out_valid = 1. result and flags are held stable until out_valid & out_ready.
  - Handshake with no accept in the same cycle: out_valid -> 0, go to IDLE.
  - Handshake with accept in the same cycle (back-to-back): out_valid -> 0, new operands latched, go to SETTLE. No bubble cycle in IDLE.
- op_count: +1 on every output handshake. Saturates at all-ones (no wrap).
- sticky_overflow:
  - Set at any capture edge where alu_overflow = 1.
  - Cleared by clear_sticky = 1.
  - If set and clear occur at the same edge, set wins.
- Reset mid-operation: any in-flight request is discarded. No output is produced for it and op_count is unchanged (returns to 0).
- Flags are pass-through captures. No checking or modification of ALU flag values.
- Capture occurs only from SETTLE. HOLD never re-samples the ALU.

Test Plan:
- ADD, SETTLE_CYCLES=4, bench ALU connected: accept operandA=5, operandB=7, command=0 at edge N -> out_valid rises after edge N+4, result=12, overflow=0. alu_* stable for the whole window.
- SUB then SLT, out_ready held high: back-to-back requests (3-3, then 2<5) -> results 0 then 1. Second request accepted on the first output handshake edge with no idle cycle. op_count=2.
- Overflow and sticky: ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, sticky_overflow=1. Next ADD 1+1 leaves sticky=1. clear_sticky pulse -> 0. clear_sticky on a capture edge with overflow=1 -> stays 1.
- Backpressure: out_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, result/flags unchanged, no new accept. out_ready=1 -> handshake, and the pending request is accepted the same edge.
- Reset mid-SETTLE (after 2 of 4 cycles) -> next edge: out_valid=0, state IDLE, op_count=0, all outputs 0. in_ready=1 on the first cycle after reset deasserts.
- SETTLE_CYCLES=1 and op_count saturation (CNT_WIDTH=2): latency of 1 edge. Five handshakes -> op_count = 3.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around a combinational ALU: holds operands for a settle
// window, captures result and flags, and presents them over valid/ready.
module alu_issue_stage #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     operandA,
  input  logic [WIDTH-1:0]     operandB,
  input  logic [2:0]           command,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  output logic [2:0]           alu_command,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carryout,
  output logic                 zero,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic                 sticky_overflow,
  input  logic                 clear_sticky
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [7:0]           SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [7:0]           settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [2:0]           alu_cmd_q, alu_cmd_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
  logic                 sticky_q, sticky_d;
  logic                 accept;
  logic                 out_hs;

  assign in_ready = ~reset & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cmd_d    = alu_cmd_q;
    result_d     = result_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid_q;
    op_count_d   = op_count_q;
    // Clear is applied first so a same-edge capture overflow wins.
    sticky_d     = clear_sticky ? 1'b0 : sticky_q;

    case (state_q)
      IDLE: ;
      SETTLE: begin
        if (settle_cnt_q > 8'd1) begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end else begin
          result_d    = alu_result;
          carry_d     = alu_carryout;
          zero_d      = alu_zero;
          ovf_d       = alu_overflow;
          out_valid_d = 1'b1;
          state_d     = HOLD;
          if (alu_overflow) sticky_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (op_count_q != '1) op_count_d = op_count_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only occurs in IDLE or HOLD, so it overrides the HOLD->IDLE move.
    if (accept) begin
      alu_a_d      = operandA;
      alu_b_d      = operandB;
      alu_cmd_d    = command;
      settle_cnt_d = SETTLE_INIT;
      state_d      = SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      op_count_q   <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cmd_q    <= alu_cmd_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      op_count_q   <= op_count_d;
      sticky_q     <= sticky_d;
    end
  end

  assign alu_operandA    = alu_a_q;
  assign alu_operandB    = alu_b_q;
  assign alu_command     = alu_cmd_q;
  assign result          = result_q;
  assign carryout        = carry_q;
  assign zero            = zero_q;
  assign overflow        = ovf_q;
  assign out_valid       = out_valid_q;
  assign op_count        = op_count_q;
  assign sticky_overflow = sticky_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps plus a randomized run against a
// transaction-level model; a second instance covers SETTLE_CYCLES=1 and a 2-bit count.
module tb_alu_issue_stage;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // Bench ALU; packed as {carryout, zero, overflow, result}.
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy;
    logic        ov;
    s  = '0;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                  ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                  ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {cy, (r == 32'd0), ov, r};
  endfunction

  // Instance 0: defaults (SETTLE_CYCLES=4, CNT_WIDTH=16)
  logic        rst0, iv0, or0, clr0, ir0, ovl0, cy0, z0, of0, st0;
  logic [31:0] a0, b0, aa0, ab0, ar0, res0;
  logic [2:0]  cmd0, ac0;
  logic        acy0, az0, aov0;
  logic [15:0] cnt0;
  assign {acy0, az0, aov0, ar0} = alu_f(aa0, ab0, ac0);

  alu_issue_stage u0 (
    .clk(clk), .reset(rst0), .in_valid(iv0), .in_ready(ir0),
    .operandA(a0), .operandB(b0), .command(cmd0),
    .alu_operandA(aa0), .alu_operandB(ab0), .alu_command(ac0),
    .alu_result(ar0), .alu_carryout(acy0), .alu_zero(az0), .alu_overflow(aov0),
    .out_valid(ovl0), .out_ready(or0), .result(res0), .carryout(cy0), .zero(z0),
    .overflow(of0), .op_count(cnt0), .sticky_overflow(st0), .clear_sticky(clr0)
  );

  // Instance 1: single-cycle settle, 2-bit saturating count
  logic        rst1, iv1, or1, clr1, ir1, ovl1, cy1, z1, of1, st1;
  logic [31:0] a1, b1, aa1, ab1, ar1, res1;
  logic [2:0]  cmd1, ac1;
  logic        acy1, az1, aov1;
  logic [1:0]  cnt1;
  assign {acy1, az1, aov1, ar1} = alu_f(aa1, ab1, ac1);

  alu_issue_stage #(.WIDTH(32), .SETTLE_CYCLES(1), .CNT_WIDTH(2)) u1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1),
    .operandA(a1), .operandB(b1), .command(cmd1),
    .alu_operandA(aa1), .alu_operandB(ab1), .alu_command(ac1),
    .alu_result(ar1), .alu_carryout(acy1), .alu_zero(az1), .alu_overflow(aov1),
    .out_valid(ovl1), .out_ready(or1), .result(res1), .carryout(cy1), .zero(z1),
    .overflow(of1), .op_count(cnt1), .sticky_overflow(st1), .clear_sticky(clr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : main
    int          exp_cnt;
    logic [31:0] sa, sb;
    // random-run model state
    bit          settling, holding, acc, hs, exp_ir, ns;
    int          left, mcnt;
    logic [31:0] ma, mb;
    logic [2:0]  mc;
    logic [34:0] mexp;
    logic        msticky;

    {rst0, iv0, or0, clr0, a0, b0, cmd0} = '0;
    {rst1, iv1, or1, clr1, a1, b1, cmd1} = '0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    tick(); tick();
    chk("rst_out_valid", ovl0, 0);
    chk("rst_op_count", cnt0, 0);
    chk("rst_sticky", st0, 0);
    chk("rst_result", res0, 0);
    chk("rst_alu_a", aa0, 0);
    chk("rst_in_ready", ir0, 0);
    chk("rst1_out_valid", ovl1, 0);
    chk("rst1_op_count", cnt1, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("post_rst_in_ready", ir0, 1);
    exp_cnt = 0;

    // ADD 5+7, latency of SETTLE_CYCLES edges, operands held throughout
    iv0 = 1; a0 = 32'd5; b0 = 32'd7; cmd0 = 3'd0;
    tick();
    iv0 = 0; a0 = $urandom; b0 = $urandom; cmd0 = 3'd6;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("add_latency", ovl0, (i == 4));
      chk("add_hold_ops", {aa0, ab0, ac0}, {32'd5, 32'd7, 3'd0});
    end
    chk("add_result", res0, 12);
    chk("add_ovf", of0, 0);
    chk("hold_in_ready_lo", ir0, 0);
    or0 = 1;
    #1;
    chk("hold_in_ready_hi", ir0, 1);
    tick();
    exp_cnt++;
    chk("add_hs_valid", ovl0, 0);
    chk("add_hs_count", cnt0, exp_cnt);

    // Back-to-back SUB 3-3 then SLT 2<5 with out_ready high
    iv0 = 1; a0 = 32'd3; b0 = 32'd3; cmd0 = 3'd1;
    tick();
    a0 = 32'd2; b0 = 32'd5; cmd0 = 3'd3;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("sub_settle_valid", ovl0, 0);
      chk("sub_settle_cmd", ac0, 1);
    end
    tick();
    chk("sub_valid", ovl0, 1);
    chk("sub_result", {z0, res0}, {1'b1, 32'd0});
    chk("b2b_in_ready", ir0, 1);
    tick();
    exp_cnt++;
    iv0 = 0;
    chk("b2b_no_bubble", {ovl0, aa0, ab0, ac0}, {1'b0, 32'd2, 32'd5, 3'd3});
    chk("b2b_count", cnt0, exp_cnt);
    tick(); tick(); tick(); tick();
    chk("slt_result", {ovl0, res0}, {1'b1, 32'd1});
    tick();
    exp_cnt++;
    chk("slt_count", cnt0, exp_cnt);
    or0 = 0;

    // Overflow capture and sticky behaviour
    iv0 = 1; a0 = 32'h7FFF_FFFF; b0 = 32'd1; cmd0 = 3'd0;
    tick(); iv0 = 0;
    tick(); tick(); tick(); tick();
    chk("ovf_result", {res0, of0, st0}, {32'h8000_0000, 1'b1, 1'b1});
    or0 = 1; tick(); or0 = 0; exp_cnt++;
    iv0 = 1; a0 = 32'd1; b0 = 32'd1;
    tick(); iv0 = 0;
    tick(); tick(); tick(); tick();
    chk("sticky_persists", {res0, of0, st0}, {32'd2, 1'b0, 1'b1});
    or0 = 1; tick(); or0 = 0; exp_cnt++;
    clr0 = 1; tick(); clr0 = 0;
    chk("sticky_cleared", st0, 0);
    iv0 = 1; a0 = 32'h7FFF_FFFF; b0 = 32'd1;
    tick(); iv0 = 0;
    tick(); tick(); tick();
    clr0 = 1; tick(); clr0 = 0;
    chk("sticky_set_wins", {ovl0, st0}, {1'b1, 1'b1});

    // Backpressure in HOLD with a pending request
    iv0 = 1; a0 = 32'hA5A5_A5A5; b0 = 32'hFFFF_0000; cmd0 = 3'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", ir0, 0);
      chk("bp_hold", {ovl0, res0, of0, aa0}, {1'b1, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF});
    end
    or0 = 1;
    #1;
    chk("bp_release_ready", ir0, 1);
    tick();
    exp_cnt++;
    chk("bp_hs_accept", {ovl0, aa0, cnt0}, {1'b0, 32'hA5A5_A5A5, 16'(exp_cnt)});
    iv0 = 0; or0 = 0;
    tick(); tick(); tick(); tick();
    chk("xor_result", res0, 32'hA5A5_A5A5 ^ 32'hFFFF_0000);
    or0 = 1; tick(); or0 = 0; exp_cnt++;
    chk("xor_count", cnt0, exp_cnt);

    // Reset after 2 of 4 settle cycles discards the request
    iv0 = 1; a0 = 32'd9; b0 = 32'd9; cmd0 = 3'd0;
    tick(); iv0 = 0;
    tick(); tick();
    rst0 = 1;
    tick();
    chk("midrst_outputs", {ovl0, cnt0, aa0, res0, st0}, '0);
    chk("midrst_in_ready", ir0, 0);
    rst0 = 0;
    #1;
    chk("midrst_ready_after", ir0, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_output", ovl0, 0);
    end

    // Randomized run against a transaction-level model
    settling = 0; holding = 0; left = 0; mcnt = 0; msticky = 0;
    ma = '0; mb = '0; mc = '0; mexp = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      iv0  = ($urandom_range(0, 2) != 0);
      a0   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      b0   = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      cmd0 = 3'($urandom_range(0, 7));
      or0  = ($urandom_range(0, 3) != 0);
      clr0 = ($urandom_range(0, 7) == 0);
      #1;
      exp_ir = (!settling && !holding) || (holding && or0);
      chk("rnd_in_ready", ir0, exp_ir);
      acc = iv0 && exp_ir;
      hs  = holding && or0;
      if (hs) chk("rnd_result", {cy0, z0, of0, res0}, mexp);
      ns = clr0 ? 1'b0 : msticky;
      if (hs) begin
        holding = 0;
        if (mcnt < 65535) mcnt++;
      end
      if (settling) begin
        if (left > 1) left--;
        else begin
          settling = 0;
          holding  = 1;
          mexp     = alu_f(ma, mb, mc);
          if (mexp[32]) ns = 1'b1;
        end
      end
      msticky = ns;
      if (acc) begin
        settling = 1; left = 4; ma = a0; mb = b0; mc = cmd0;
      end
      tick();
      chk("rnd_out_valid", ovl0, holding);
      chk("rnd_count", cnt0, mcnt);
      chk("rnd_sticky", st0, msticky);
      if (settling || holding) chk("rnd_alu_ops", {aa0, ab0, ac0}, {ma, mb, mc});
    end

    // SETTLE_CYCLES=1 latency and 2-bit count saturation
    for (int k = 1; k <= 5; k++) begin
      sa = $urandom; sb = $urandom;
      iv1 = 1; a1 = sa; b1 = sb; cmd1 = 3'd7;
      tick();
      iv1 = 0;
      chk("s1_not_yet", ovl1, 0);
      tick();
      chk("s1_latency", {ovl1, res1}, {1'b1, sa | sb});
      or1 = 1;
      tick();
      or1 = 0;
      chk("s1_sat_count", {ovl1, cnt1}, {1'b0, 2'((k > 3) ? 3 : k)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
